// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and the decode stage:
// FSM state encoding and a constant-evaluable clog2 helper.
package regfile_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Issue scoreboard: one pending bit per architectural register.
// An issued destination becomes pending; a writeback clears it. When an issue
// and a writeback hit the same register in one cycle the issue wins, because
// the new producer is still outstanding. Register 0 is never pending.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = clog2(NREG),
  parameter int NWR  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  output logic [NREG-1:0]   pend
);

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pend_nxt;

  // Next pending vector: clears from writebacks, then sets from issue on top.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (run) begin
      for (int p = 0; p < NWR; p++) begin
        if (wen[p]) clr_mask[waddr[p*AW +: AW]] = 1'b1;
      end
      if (set_en) set_mask[set_addr] = 1'b1;
    end
    pend_nxt    = (pend & ~clr_mask) | set_mask;
    pend_nxt[0] = 1'b0;
  end

  // Pending vector register; reset leaves nothing outstanding.
  always_ff @(posedge clk) begin
    if (!rst) pend <= '0;
    else      pend <= pend_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with zero-latency reads, same-cycle write bypass,
// an issue scoreboard, and a post-reset sweep that zeroes every register.
// Register 0 is hardwired to zero and is never stored or marked pending.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rpend_o,
  input  logic [NWR-1:0]      wen_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic                set_en_i,
  input  logic [AW-1:0]       set_addr_i,
  output logic                busy_o
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  state_e          state_q;
  logic [AW-1:0]   sweep_q;
  logic            busy_q;
  logic            run;
  logic [NWR-1:0]  wen_run;
  logic [NREG-1:0] pend;
  logic [XLEN-1:0] mem [NREG];

  assign run     = (state_q == RUN);
  assign busy_o  = busy_q;
  assign wen_run = run ? wen_i : '0;

  // Sweep FSM: reset restarts the zeroing pass at index 1; RUN follows the
  // cycle that clears the last register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      sweep_q <= FIRST_IDX;
      busy_q  <= 1'b1;
    end else if (state_q == INIT) begin
      if (sweep_q == LAST_IDX) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end else begin
        sweep_q <= sweep_q + FIRST_IDX;
      end
    end
  end

  // Storage: the sweep owns the array in INIT; in RUN the ports write in
  // ascending order so the highest-numbered port to an address lands last.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!run) begin
        mem[sweep_q] <= '0;
      end else begin
        for (int p = 0; p < NWR; p++) begin
          if (wen_i[p] && (waddr_i[p*AW +: AW] != '0))
            mem[waddr_i[p*AW +: AW]] <= wdata_i[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Read ports: stored value, overridden by the highest matching write port;
  // a bypassed read is by definition no longer waiting on its producer.
  always_comb begin
    rdata_o = '0;
    rpend_o = '0;
    for (int k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      logic            hit;
      ra  = raddr_i[k*AW +: AW];
      rd  = mem[ra];
      hit = 1'b0;
      for (int p = 0; p < NWR; p++) begin
        if (wen_run[p] && (waddr_i[p*AW +: AW] == ra)) begin
          hit = 1'b1;
          rd  = wdata_i[p*XLEN +: XLEN];
        end
      end
      if (!run || (ra == '0)) begin
        rd  = '0;
        hit = 1'b0;
      end
      rdata_o[k*XLEN +: XLEN] = rd;
      rpend_o[k] = run && (ra != '0) && !hit && pend[ra];
    end
  end

  regfile_sb #(
    .NREG (NREG),
    .AW   (AW),
    .NWR  (NWR)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .set_en   (set_en_i),
    .set_addr (set_addr_i),
    .wen      (wen_i),
    .waddr    (waddr_i),
    .pend     (pend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp with default parameters (32 x 32-bit, 2R/2W).
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  raddr_i;
  logic [63:0] rdata_o;
  logic [1:0]  rpend_o;
  logic [1:0]  wen_i;
  logic [9:0]  waddr_i;
  logic [63:0] wdata_i;
  logic        set_en_i;
  logic [4:0]  set_addr_i;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        se;
    logic [4:0]  sa;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        p0;
    logic        p1;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        p0;
    logic        p1;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[12];

  regfile_mp dut (
    .clk        (clk),
    .rst        (rst),
    .raddr_i    (raddr_i),
    .rdata_o    (rdata_o),
    .rpend_o    (rpend_o),
    .wen_i      (wen_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .set_en_i   (set_en_i),
    .set_addr_i (set_addr_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic se, input logic [4:0] sa,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic p0, input logic p1);
    vec_t v;
    v.wen = wen; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.se = se; v.sa = sa;
    v.d0 = d0; v.d1 = d1; v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic push_exp(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                          input logic p0, input logic p1);
    exp_t e;
    e.nm = nm; e.d0 = d0; e.d1 = d1; e.p0 = p0; e.p1 = p1;
    sb_q.push_back(e);
  endtask

  task automatic check_q();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.nm, "_rdata0"}, rdata_o[31:0], e.d0);
      chk({e.nm, "_rdata1"}, rdata_o[63:32], e.d1);
      chk({e.nm, "_rpend0"}, 32'(rpend_o[0]), 32'(e.p0));
      chk({e.nm, "_rpend1"}, 32'(rpend_o[1]), 32'(e.p1));
    end
  endtask

  task automatic drive(input vec_t v);
    wen_i      = v.wen;
    waddr_i    = {v.wa1, v.wa0};
    wdata_i    = {v.wd1, v.wd0};
    raddr_i    = {v.ra1, v.ra0};
    set_en_i   = v.se;
    set_addr_i = v.sa;
  endtask

  task automatic idle_inputs();
    wen_i = '0; waddr_i = '0; wdata_i = '0; set_en_i = 1'b0; set_addr_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the sample point just after the reset edge, with rst released.
  task automatic count_busy(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_o) break;
      n++;
      step();
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'd31);
    chk({nm, "_busy_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    raddr_i = '0;
    idle_inputs();

    tbl[0]  = mk(2'b01, 5, 32'h1234,     0, 0,          5,  5,  0, 0,  32'h1234, 32'h1234, 0, 0);
    tbl[1]  = mk(2'b00, 0, 0,            0, 0,          5,  0,  0, 0,  32'h1234, 0,        0, 0);
    tbl[2]  = mk(2'b11, 7, 32'hAAAA,     7, 32'h5555,   7,  5,  0, 0,  32'h5555, 32'h1234, 0, 0);
    tbl[3]  = mk(2'b00, 0, 0,            0, 0,          7,  7,  0, 0,  32'h5555, 32'h5555, 0, 0);
    tbl[4]  = mk(2'b11, 0, 32'hFFFFFFFF, 3, 32'h3333,   0,  3,  1, 0,  0,        32'h3333, 0, 0);
    tbl[5]  = mk(2'b00, 0, 0,            0, 0,          0,  3,  0, 0,  0,        32'h3333, 0, 0);
    tbl[6]  = mk(2'b00, 0, 0,            0, 0,          12, 7,  1, 12, 0,        32'h5555, 0, 0);
    tbl[7]  = mk(2'b00, 0, 0,            0, 0,          12, 12, 0, 0,  0,        0,        1, 1);
    tbl[8]  = mk(2'b10, 0, 0,            12, 32'hCC,    12, 5,  0, 0,  32'hCC,   32'h1234, 0, 0);
    tbl[9]  = mk(2'b00, 0, 0,            0, 0,          12, 3,  0, 0,  32'hCC,   32'h3333, 0, 0);
    tbl[10] = mk(2'b11, 3, 32'h1,        5, 32'h2,      5,  3,  0, 0,  32'h2,    32'h1,    0, 0);
    tbl[11] = mk(2'b00, 0, 0,            0, 0,          3,  5,  0, 0,  32'h1,    32'h2,    0, 0);

    // Reset state
    step();
    chk("reset_busy", 32'(busy_o), 32'd1);
    chk("reset_rdata", rdata_o[31:0], 32'd0);
    chk("reset_rpend", 32'(rpend_o), 32'd0);
    rst = 1'b1;
    count_busy("init");

    // Every address reads zero after the sweep
    for (int a = 0; a < 32; a++) begin
      raddr_i = {5'(a), 5'(a)};
      #1;
      chk($sformatf("zero_x%0d_p0", a), rdata_o[31:0], 32'd0);
      chk($sformatf("zero_x%0d_p1", a), rdata_o[63:32], 32'd0);
      chk($sformatf("zero_pend_x%0d", a), 32'(rpend_o), 32'd0);
    end
    step();

    // Table vectors: bypass, priority, x0 discard, scoreboard set/clear
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      push_exp($sformatf("vec%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].p0, tbl[i].p1);
      #1;
      check_q();
      step();
    end
    idle_inputs();

    // Set x9, then write x9 while setting it again in the same cycle
    set_en_i = 1'b1; set_addr_i = 5'd9; raddr_i = {5'd9, 5'd9};
    push_exp("set9_issue", 0, 0, 0, 0);
    #1; check_q();
    step();
    push_exp("set9_pending", 0, 0, 1, 1);
    #1; check_q();
    wen_i = 2'b01; waddr_i = {5'd0, 5'd9}; wdata_i = {32'h0, 32'h42}; raddr_i = {5'd3, 5'd9};
    push_exp("set9_bypass", 32'h42, 32'h1, 0, 0);
    #1; check_q();
    step();
    idle_inputs();
    push_exp("set9_after", 32'h42, 32'h1, 1, 0);
    #1; check_q();
    wen_i = 2'b10; waddr_i = {5'd9, 5'd0}; wdata_i = {32'h77, 32'h0};
    push_exp("clr9_bypass", 32'h77, 32'h1, 0, 0);
    #1; check_q();
    step();
    idle_inputs();
    push_exp("clr9_after", 32'h77, 32'h1, 0, 0);
    #1; check_q();

    // Reset during RUN, then again mid-sweep at index 10, writes attempted throughout
    rst = 1'b0;
    step();
    rst = 1'b1;
    wen_i = 2'b11; waddr_i = {5'd7, 5'd5}; wdata_i = {32'hBEEF, 32'hDEAD};
    set_en_i = 1'b1; set_addr_i = 5'd5; raddr_i = {5'd7, 5'd5};
    repeat (9) step();
    chk("midsweep_busy", 32'(busy_o), 32'd1);
    push_exp("midsweep_read", 0, 0, 0, 0);
    #1; check_q();
    rst = 1'b0;
    step();
    rst = 1'b1;
    count_busy("restart");
    idle_inputs();
    raddr_i = {5'd7, 5'd5};
    push_exp("restart_x5_x7", 0, 0, 0, 0);
    #1; check_q();
    raddr_i = {5'd12, 5'd9};
    push_exp("restart_x9_x12", 0, 0, 0, 0);
    #1; check_q();
    step();
    push_exp("restart_settled", 0, 0, 0, 0);
    #1; check_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
